seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 3'b101, N bits wide, MSB received first.
REQ-003 The block SHALL have parameter OVERLAP, default 0, meaning 0 = non-overlapping and 1 = overlapping detection.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port data  input  1  serial bit under test.
REQ-008 Port valid  input  1  data qualifier; data is consumed only on edges where valid=1.
REQ-009 Port generated  output  1  Moore detect flag, high while the FSM is in the match state.
REQ-010 Port match_count  output  CNT_W  saturating count of matches since reset.
REQ-011 Port count_clr  input  1  synchronous clear of match_count only.

Function
REQ-012 The FSM SHALL have N+1 states S0..SN, where Sk means "last k consumed bits equal PATTERN[N-1:N-k]". SN is the match state.
REQ-013 From Sk (k<N), when the consumed bit equals PATTERN[N-1-k], the FSM SHALL go to Sk+1.
REQ-014 From Sk (k<N), on a mismatch, the FSM SHALL go to Sj. j is the length of the longest proper suffix of (matched prefix, bit) that is also a pattern prefix (KMP fallback, j may be 0).
REQ-015 From SN with OVERLAP=0, the FSM SHALL treat the consumed bit as if in S0 (next = S1 if bit==PATTERN[N-1], else S0).
REQ-016 From SN with OVERLAP=1, the FSM SHALL apply REQ-013/014 starting from Sf, where f is the longest proper border of PATTERN.
REQ-017 generated SHALL equal (state==SN), registered, with no combinational path from data. It is high for the single cycle following the edge that consumed the last pattern bit.
REQ-018 On edges with valid=0, state SHALL hold, including SN, so generated stays high until the next valid bit.
REQ-019 match_count SHALL increment by 1 on each edge where the state transitions into SN, including SN->SN (possible only when OVERLAP=1 and the pattern is periodic with border N-1, e.g. all-ones).
REQ-020 match_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 count_clr=1 SHALL clear match_count to 0 and take priority over a simultaneous increment; the FSM is unaffected.
REQ-022 Undefined state encodings SHALL recover to S0 on the next edge.

Reset
REQ-023 While rst=1 at an edge, the state SHALL become S0, generated=0 and match_count=0, regardless of valid, data or count_clr.
REQ-024 Reset mid-sequence SHALL discard all partial-match progress; the first valid bit after rst deasserts is evaluated from S0.

Structure
REQ-025 A shared package seq_detect_pkg SHALL hold the state-width function clog2(N+1), the KMP next-state elaboration function (pattern, N, k, bit -> next k) and the border-length function. The transition table is computed at elaboration, not at run time.
REQ-026 One sub-module, seq_match_counter (CNT_W parameter; inputs clk, rst, inc, clr; output count), SHALL implement REQ-019 to REQ-021.
REQ-027 The state register SHALL be binary-encoded, width clog2(N+1).

Verification
REQ-028 Default params, valid=1, data 1,0,1,0,1 -> generated high only in the cycle after bit 3; match_count=1.
REQ-029 OVERLAP=1, same stimulus 1,0,1,0,1 -> generated high after bit 3 and after bit 5; match_count=2.
REQ-030 N=4, PATTERN=4'b1101, data 1,1,1,0,1 -> KMP fallback keeps S2 on the third 1; generated high after bit 5.
REQ-031 Default params, data 1,0,(valid=0 for 3 cycles),1 -> state holds through the stall; generated high after the final valid 1 and stays high while valid=0.
REQ-032 Data 1,0 then rst=1 for one cycle, then 1 -> no detect, state=S1; then 0,1 -> detect, match_count=1.
REQ-033 CNT_W=2, OVERLAP=1, PATTERN=3'b111, data=1 for 10 cycles -> match_count saturates at 3; count_clr together with a match -> 0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared elaboration-time helpers for the parameterised serial pattern detector.
//
// Purpose:
//   Holds the constant functions used to build the detector's transition
//   table when the design is elaborated. Nothing here produces run-time
//   logic by itself.
//
// Contents:
//   MAX_N        - widest pattern supported (16 bits)
//   state_width  - bits needed to binary-encode states S0..SN
//   border_len   - longest proper border of the pattern
//   kmp_next     - KMP successor state of Sk on a received bit
//   next_state   - full successor, including match-state and illegal codes
package seq_detect_pkg;

    localparam int MAX_N   = 16;
    localparam int PIDX_W  = $clog2(MAX_N);
    localparam int SIDX_W  = $clog2(MAX_N + 1);

    // Bits needed to encode states S0..SN as a plain binary index.
    function automatic int state_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Longest j < n such that the first j received pattern bits equal the
    // last j pattern bits. The pattern is stored MSB-first in [n-1:0].
    function automatic int border_len(input logic [MAX_N-1:0] pattern,
                                      input int n);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < n; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                if (pattern[PIDX_W'(n-1-t)] != pattern[PIDX_W'(j-1-t)])
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        return best;
    endfunction

    // From Sk (k < n), having matched the first k pattern bits, receive bit b.
    // The result is the length of the longest suffix of (prefix_k, b) that is
    // also a pattern prefix. A full extension yields k+1, so the forward step
    // and the KMP fallback come out of the same search.
    function automatic int kmp_next(input logic [MAX_N-1:0] pattern,
                                    input int n,
                                    input int k,
                                    input logic b);
        logic [MAX_N:0] seq;
        int             best;
        logic           ok;
        seq = '0;
        for (int i = 0; i < k; i++)
            seq[SIDX_W'(i)] = pattern[PIDX_W'(n-1-i)];
        seq[SIDX_W'(k)] = b;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            if (j <= n) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    if (seq[SIDX_W'(k+1-j+t)] != pattern[PIDX_W'(n-1-t)])
                        ok = 1'b0;
                end
                if (ok)
                    best = j;
            end
        end
        return best;
    endfunction

    // Complete successor function for any state code. The match state restarts
    // from S0 (non-overlapping) or from the pattern border (overlapping);
    // codes beyond SN fall back to S0.
    function automatic int next_state(input logic [MAX_N-1:0] pattern,
                                      input int n,
                                      input int overlap,
                                      input int k,
                                      input logic b);
        int start;
        if (k > n)
            return 0;
        if (k == n)
            start = (overlap != 0) ? border_len(pattern, n) : 0;
        else
            start = k;
        return kmp_next(pattern, n, start, b);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter for the serial pattern detector.
//
// Purpose:
//   Counts match events, sticks at its all-ones value instead of wrapping,
//   and can be cleared without touching anything else.
//
// Ports:
//   clk   - clock, all updates on the rising edge
//   rst   - synchronous active-high reset, clears the count
//   inc   - add one this edge (ignored once saturated)
//   clr   - synchronous clear, wins over a simultaneous inc
//   count - current count, CNT_W bits
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear beats increment; the count freezes at CNT_MAX.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != CNT_MAX))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector (Moore FSM) with a match counter.
//
// Purpose:
//   Watches a qualified serial bit stream for an N-bit pattern, received
//   MSB first. States S0..SN record how many leading pattern bits currently
//   line up with the tail of the stream. SN is the match state. The
//   transition table is built at elaboration with KMP fallback, so partial
//   progress is never lost unnecessarily.
//
// Parameters:
//   N        - pattern length, 2..16
//   PATTERN  - N-bit pattern, MSB received first
//   OVERLAP  - 0: restart after a match, 1: reuse the pattern border
//   CNT_W    - width of match_count
//
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   data         - serial bit under test
//   valid        - data is consumed only on edges where valid is high
//   count_clr    - synchronous clear of match_count only
//   generated    - registered flag, high while the FSM sits in SN
//   match_count  - saturating number of entries into SN since reset
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int           N       = 3,
    parameter logic [N-1:0] PATTERN = 3'b101,
    parameter int           OVERLAP = 0,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             valid,
    input  logic             count_clr,
    output logic             generated,
    output logic [CNT_W-1:0] match_count
);

    localparam int               SW        = state_width(N);
    localparam int               NUM_CODES = 1 << SW;
    localparam logic [MAX_N-1:0] PAT_EXT   = MAX_N'(PATTERN);
    localparam logic [SW-1:0]    S_IDLE    = '0;
    localparam logic [SW-1:0]    S_MATCH   = SW'(N);

    if ((N < 2) || (N > MAX_N)) begin : g_bad_n
        $error("seq_detect_param: N must lie in 2..16");
    end

    logic [SW-1:0] state;
    logic [SW-1:0] nxt;
    logic          state_legal;
    logic          enter_match;
    logic [SW-1:0] next_on0 [NUM_CODES];
    logic [SW-1:0] next_on1 [NUM_CODES];

    // Transition table, one entry per possible state code and input bit.
    // Every entry is an elaboration-time constant; unused codes map to S0.
    for (genvar k = 0; k < NUM_CODES; k++) begin : g_table
        localparam int NXT0 = next_state(PAT_EXT, N, OVERLAP, k, 1'b0);
        localparam int NXT1 = next_state(PAT_EXT, N, OVERLAP, k, 1'b1);
        assign next_on0[k] = SW'(NXT0);
        assign next_on1[k] = SW'(NXT1);
    end

    // Codes above SN only exist when N+1 is not a power of two.
    if (NUM_CODES > N + 1) begin : g_legal_chk
        assign state_legal = (state <= S_MATCH);
    end else begin : g_legal_all
        assign state_legal = 1'b1;
    end

    // Successor for the bit on the wire, and whether this edge lands in SN.
    // Illegal codes already map to S0, so they can never claim a match.
    always_comb begin
        nxt         = S_IDLE;
        enter_match = 1'b0;
        nxt         = data ? next_on1[state] : next_on0[state];
        enter_match = valid && (nxt == S_MATCH);
    end

    // State register. generated is registered alongside it from the same
    // next value, so it tracks state==SN with no path from data. An illegal
    // code recovers to S0 even on a stalled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            generated <= 1'b0;
        end else if (!state_legal) begin
            state     <= S_IDLE;
            generated <= 1'b0;
        end else if (valid) begin
            state     <= nxt;
            generated <= (nxt == S_MATCH);
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (enter_match),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param.
//
// Four detectors share one stimulus stream:
//   dut0: N=3 PATTERN=101  OVERLAP=0 CNT_W=8
//   dut1: N=3 PATTERN=101  OVERLAP=1 CNT_W=8
//   dut2: N=4 PATTERN=1101 OVERLAP=0 CNT_W=8
//   dut3: N=3 PATTERN=111  OVERLAP=1 CNT_W=2
// Each vector lists the inputs for one edge and the hand-derived outputs
// of every detector after that edge.
module tb_seq_detect_param;

    logic clk;
    logic rst;
    logic data;
    logic valid;
    logic count_clr;

    logic [3:0] gen_mon;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [7:0] cnt2;
    logic [1:0] cnt3;
    logic [7:0] cnt_mon [4];

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       data;
        logic       clr;
        logic [3:0] egen;
        logic [7:0] c3;
        logic [7:0] c2;
        logic [7:0] c1;
        logic [7:0] c0;
    } vec_t;

    vec_t vecs [$];

    seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .count_clr(count_clr),
        .generated(gen_mon[0]), .match_count(cnt0));

    seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .count_clr(count_clr),
        .generated(gen_mon[1]), .match_count(cnt1));

    seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .count_clr(count_clr),
        .generated(gen_mon[2]), .match_count(cnt2));

    seq_detect_param #(.N(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .count_clr(count_clr),
        .generated(gen_mon[3]), .match_count(cnt3));

    assign cnt_mon[0] = cnt0;
    assign cnt_mon[1] = cnt1;
    assign cnt_mon[2] = cnt2;
    assign cnt_mon[3] = {6'b0, cnt3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic d,
                                input logic c, input logic [3:0] g,
                                input int e3, input int e2, input int e1,
                                input int e0);
        vec_t x;
        x.rst   = r;
        x.valid = v;
        x.data  = d;
        x.clr   = c;
        x.egen  = g;
        x.c3    = 8'(e3);
        x.c2    = 8'(e2);
        x.c1    = 8'(e1);
        x.c0    = 8'(e0);
        return x;
    endfunction

    // Drive one edge's inputs, let the edge happen, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic v, input logic d,
                                 input logic c);
        rst       = r;
        valid     = v;
        data      = d;
        count_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input logic [3:0] egen, input logic [7:0] c3,
                               input logic [7:0] c2, input logic [7:0] c1,
                               input logic [7:0] c0, input string tag);
        logic [7:0] ec [4];
        ec[0] = c0;
        ec[1] = c1;
        ec[2] = c2;
        ec[3] = c3;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (gen_mon[d] !== egen[d]) begin
                errors++;
                $display("[TB] FAIL %s dut%0d generated: got %b expected %b",
                         tag, d, gen_mon[d], egen[d]);
            end
            checks++;
            if (cnt_mon[d] !== ec[d]) begin
                errors++;
                $display("[TB] FAIL %s dut%0d match_count: got %0d expected %0d",
                         tag, d, cnt_mon[d], ec[d]);
            end
        end
    endtask

    initial begin
        int e3;
        logic [3:0] g;

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        valid     = 1'b0;
        data      = 1'b0;
        count_clr = 1'b0;

        // 1,0,1,0,1: non-overlap hits once, overlap hits twice
        vecs.push_back(mk(1,0,0,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0011, 0,0,1,1));
        vecs.push_back(mk(0,1,0,0, 4'b0000, 0,0,1,1));
        vecs.push_back(mk(0,1,1,0, 4'b0010, 0,0,2,1));
        // reset wins over valid data; then 1,1,1,0,1 exercises KMP fallback
        vecs.push_back(mk(1,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b1000, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'b0000, 1,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0111, 1,1,1,1));
        // stall in mid-pattern and in the match state
        vecs.push_back(mk(1,0,1,1, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,0,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,0,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,0,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0011, 0,0,1,1));
        vecs.push_back(mk(0,0,0,0, 4'b0011, 0,0,1,1));
        vecs.push_back(mk(0,0,0,0, 4'b0011, 0,0,1,1));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,1,1));
        // mid-sequence reset discards progress
        vecs.push_back(mk(1,0,0,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(1,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'b0000, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0, 4'b0011, 0,0,1,1));
        // count_clr on a stalled edge clears counts, flags untouched
        vecs.push_back(mk(0,0,0,1, 4'b0011, 0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].clr);
            checkOutput(vecs[i].egen, vecs[i].c3, vecs[i].c2, vecs[i].c1,
                        vecs[i].c0, $sformatf("vec%0d", i));
        end

        // Saturation: all-ones pattern with overlap on a steady stream of 1s
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, "sat_reset");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            e3 = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            g  = (i >= 3) ? 4'b1000 : 4'b0000;
            checkOutput(g, 8'(e3), 8'd0, 8'd0, 8'd0, $sformatf("sat_bit%0d", i));
        end

        // clear coinciding with an SN->SN match: clear wins
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput(4'b1000, 8'd0, 8'd0, 8'd0, 8'd0, "clr_vs_match");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput(4'b1000, 8'd1, 8'd0, 8'd0, 8'd0, "match_after_clr");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput(4'b1000, 8'd0, 8'd0, 8'd0, 8'd0, "clr_fsm_kept");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, "leave_match");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
